fft_sram_arb: RTL

FFT_SRAM_ARB -- requirements
Module: fft_sram_arb

---
 rtl/fft_sram_arb.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_sram_arb.sv
// Two-port arbiter sharing one 128-bit SRAM between the FFT core (full rows)
// and the scan path (32-bit lanes). One access in flight; every output registered.
module fft_sram_arb #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fft_prio,
  input  logic         scan_req,
  input  logic         scan_we,
  input  logic [9:0]   scan_addr,
  input  logic [31:0]  scan_wdata,
  output logic         scan_ack,
  output logic [31:0]  scan_rdata,
  output logic         scan_err,
  input  logic         fft_req,
  input  logic         fft_we,
  input  logic [7:0]   fft_addr,
  input  logic [127:0] fft_wdata,
  output logic         fft_ack,
  output logic [127:0] fft_rdata,
  output logic         fft_err,
  output logic         sram_ren,
  output logic         sram_wen,
  output logic [7:0]   sram_addr,
  output logic [127:0] sram_bweb,
  output logic [127:0] sram_wdata,
  input  logic [127:0] sram_rdata,
  input  logic         sram_ready,
  output logic         busy
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic       fft;
    logic       we;
    logic [1:0] lane;
  } acc_t;

  logic [1:0]   state_q, state_d;
  acc_t         acc_q, acc_d;
  logic         last_fft_q, last_fft_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         ren_q, ren_d, wen_q, wen_d;
  logic [7:0]   addr_q, addr_d;
  logic [127:0] bweb_q, bweb_d, wdata_q, wdata_d;
  logic         fft_ack_q, fft_ack_d, fft_err_q, fft_err_d;
  logic [127:0] fft_rdata_q, fft_rdata_d;
  logic         scan_ack_q, scan_ack_d, scan_err_q, scan_err_d;
  logic [31:0]  scan_rdata_q, scan_rdata_d;
  logic         busy_q, busy_d;

  logic         grant_fft;
  logic         rsp_fire, rsp_err;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_lanes, wr_mask;

  assign rd_lanes = sram_rdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign wr_mask[g] = (scan_addr[1:0] == 2'(g)) ? '0 : '1;
  end

  // A contested round-robin decision goes to whichever port was not served last.
  assign grant_fft = fft_req & (fft_prio | ~scan_req | ~last_fft_q);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    last_fft_d   = last_fft_q;
    cnt_d        = cnt_q;
    ren_d        = 1'b0;
    wen_d        = 1'b0;
    addr_d       = '0;
    bweb_d       = '1;
    wdata_d      = '0;
    fft_ack_d    = 1'b0;
    fft_err_d    = fft_err_q;
    fft_rdata_d  = fft_rdata_q;
    scan_ack_d   = 1'b0;
    scan_err_d   = scan_err_q;
    scan_rdata_d = scan_rdata_q;
    rsp_fire     = 1'b0;
    rsp_err      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fft_req || scan_req) begin
          state_d    = S_ISSUE;
          last_fft_d = grant_fft;
          if (grant_fft) begin
            acc_d  = '{fft: 1'b1, we: fft_we, lane: 2'd0};
            addr_d = fft_addr;
            if (fft_we) begin
              wdata_d = fft_wdata;
              bweb_d  = '0;
            end
          end else begin
            acc_d  = '{fft: 1'b0, we: scan_we, lane: scan_addr[1:0]};
            addr_d = scan_addr[9:2];
            if (scan_we) begin
              wdata_d = {NUM_LANES{scan_wdata}};
              bweb_d  = wr_mask;
            end
          end
          ren_d = ~acc_d.we;
          wen_d = acc_d.we;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (sram_ready) begin
          state_d  = S_RESP;
          rsp_fire = 1'b1;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d  = S_RESP;
          rsp_fire = 1'b1;
          rsp_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Response registers load on the WAIT->RESP edge so ack and data appear together.
    if (rsp_fire) begin
      if (acc_q.fft) begin
        fft_ack_d   = 1'b1;
        fft_err_d   = rsp_err;
        fft_rdata_d = (rsp_err || acc_q.we) ? '0 : sram_rdata;
      end else begin
        scan_ack_d   = 1'b1;
        scan_err_d   = rsp_err;
        scan_rdata_d = (rsp_err || acc_q.we) ? '0 : rd_lanes[acc_q.lane];
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      last_fft_q   <= 1'b0;
      cnt_q        <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      bweb_q       <= '1;
      wdata_q      <= '0;
      fft_ack_q    <= 1'b0;
      fft_err_q    <= 1'b0;
      fft_rdata_q  <= '0;
      scan_ack_q   <= 1'b0;
      scan_err_q   <= 1'b0;
      scan_rdata_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      last_fft_q   <= last_fft_d;
      cnt_q        <= cnt_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      bweb_q       <= bweb_d;
      wdata_q      <= wdata_d;
      fft_ack_q    <= fft_ack_d;
      fft_err_q    <= fft_err_d;
      fft_rdata_q  <= fft_rdata_d;
      scan_ack_q   <= scan_ack_d;
      scan_err_q   <= scan_err_d;
      scan_rdata_q <= scan_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign sram_ren   = ren_q;
  assign sram_wen   = wen_q;
  assign sram_addr  = addr_q;
  assign sram_bweb  = bweb_q;
  assign sram_wdata = wdata_q;
  assign fft_ack    = fft_ack_q;
  assign fft_err    = fft_err_q;
  assign fft_rdata  = fft_rdata_q;
  assign scan_ack   = scan_ack_q;
  assign scan_err   = scan_err_q;
  assign scan_rdata = scan_rdata_q;
  assign busy       = busy_q;

endmodule
